down_timer: RTL and testbench

Loadable down-counting timer with prescaler, one-shot/auto-reload modes and a terminal-count pulse. It is the consumer-side counterpart of the design's loadable up-counter. Software or the control FSM loads a count; the block decrements to zero and reports expiry. The block sits beside the multicycle datapath as a timing/delay source, e.g. for wait loops and periodic events.

---
 rtl/timer_pkg.sv | 12 +
 rtl/down_timer_counter.sv | 27 ++
 rtl/down_timer.sv | 107 ++++++++++
 tb/tb_down_timer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and default sizes for the down-counting timer and its prescaler.
package timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_PRE_WIDTH = 4;

endpackage

// File: rtl/down_timer_counter.sv
// Generic loadable up-counter; load has priority over enable.
module counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= data_in;
    end else if (en) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/down_timer.sv
// Loadable down-counting timer with prescaler, one-shot/auto-reload modes,
// a one-cycle terminal-count pulse and a sticky done flag.
module down_timer
  import timer_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int PRE_WIDTH = DEF_PRE_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     load_val,
  input  logic                 load,
  input  logic [PRE_WIDTH-1:0] prescale,
  input  logic                 auto_reload,
  input  logic                 stop,
  input  logic                 done_clr,
  output logic [WIDTH-1:0]     count,
  output logic                 busy,
  output logic                 tc,
  output logic                 done
);

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     count_reg, count_next;
  logic [WIDTH-1:0]     reload_reg, reload_next;
  logic                 tc_reg, tc_next;
  logic                 done_reg, done_next;
  logic [PRE_WIDTH-1:0] pre_count;
  logic                 tick;
  logic                 busy_int;

  assign busy_int = (state_reg == RUN);
  assign tick     = busy_int && (pre_count == prescale);

  // Prescaler is held cleared outside RUN and restarts on every tick or load.
  counter #(
    .WIDTH(PRE_WIDTH)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .data_in('0),
    .load   (tick | load | ~busy_int),
    .en     (busy_int),
    .count  (pre_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      reload_reg <= '0;
      tc_reg     <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      reload_reg <= reload_next;
      tc_reg     <= tc_next;
      done_reg   <= done_next;
    end
  end

  always_comb begin
    logic done_set;
    state_next  = state_reg;
    count_next  = count_reg;
    reload_next = reload_reg;
    tc_next     = 1'b0;
    done_set    = 1'b0;

    if (load) begin
      reload_next = load_val;
      count_next  = load_val;
      if (load_val != '0) begin
        state_next = RUN;
      end else begin
        state_next = IDLE;
        tc_next    = 1'b1;
        done_set   = 1'b1;
      end
    end else if (stop && busy_int) begin
      state_next = IDLE;
    end else if (tick) begin
      // Expiry is detected at 1 so the count never wraps below zero.
      if (count_reg > WIDTH'(1)) begin
        count_next = count_reg - WIDTH'(1);
      end else begin
        tc_next  = 1'b1;
        done_set = 1'b1;
        if (auto_reload) begin
          count_next = reload_reg;
        end else begin
          count_next = '0;
          state_next = IDLE;
        end
      end
    end

    done_next = done_set ? 1'b1 : (done_clr ? 1'b0 : done_reg);
  end

  assign count = count_reg;
  assign busy  = busy_int;
  assign tc    = tc_reg;
  assign done  = done_reg;

endmodule

// File: tb/tb_down_timer.sv
// Directed plus randomized bench for down_timer, checked every cycle against
// a cycle-level behavioural model of the timer's rules.
module tb_down_timer;

  localparam int W  = 8;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  load_val;
  logic          load;
  logic [PW-1:0] prescale;
  logic          auto_reload;
  logic          stop;
  logic          done_clr;
  logic [W-1:0]  count;
  logic          busy;
  logic          tc;
  logic          done;

  int err_cnt = 0;
  int chk_cnt = 0;

  // Reference model state
  bit m_run;
  int m_cnt;
  int m_reload;
  int m_phase;
  bit m_tc;
  bit m_done;

  down_timer #(
    .WIDTH(W),
    .PRE_WIDTH(PW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_val   (load_val),
    .load       (load),
    .prescale   (prescale),
    .auto_reload(auto_reload),
    .stop       (stop),
    .done_clr   (done_clr),
    .count      (count),
    .busy       (busy),
    .tc         (tc),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge of the timer, described from its behavioural rules.
  task automatic model_edge();
    bit set_done;
    bit new_tc;
    if (rst) begin
      m_run = 0; m_cnt = 0; m_reload = 0; m_phase = 0; m_tc = 0; m_done = 0;
      return;
    end
    set_done = 0;
    new_tc   = 0;
    if (load) begin
      m_reload = int'(load_val);
      m_cnt    = int'(load_val);
      m_phase  = 0;
      if (load_val != 0) m_run = 1;
      else begin
        m_run = 0; new_tc = 1; set_done = 1;
      end
    end else if (stop && m_run) begin
      m_run = 0;
      m_phase = 0;
    end else if (m_run) begin
      if (m_phase == int'(prescale)) begin
        m_phase = 0;
        if (m_cnt > 1) m_cnt = m_cnt - 1;
        else begin
          new_tc = 1; set_done = 1;
          if (auto_reload) m_cnt = m_reload;
          else begin
            m_cnt = 0; m_run = 0;
          end
        end
      end else begin
        m_phase = (m_phase + 1) % (1 << PW);
      end
    end else begin
      m_phase = 0;
    end
    m_tc   = new_tc;
    m_done = set_done ? 1'b1 : (done_clr ? 1'b0 : m_done);
  endtask

  // Drive one cycle of inputs, advance the model, check all outputs.
  task automatic step(input logic r, input logic l, input logic [W-1:0] lv,
                      input logic st, input logic dc);
    rst = r; load = l; load_val = lv; stop = st; done_clr = dc;
    if (l && !r)
      $display("load val=%0d prescale=%0d auto_reload=%0d t=%0t", lv, prescale, auto_reload, $time);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("count", 32'(count), 32'(m_cnt));
    check("busy",  32'(busy),  32'(m_run));
    check("tc",    32'(tc),    32'(m_tc));
    check("done",  32'(done),  32'(m_done));
  endtask

  task automatic idle(input int n, input logic dc);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, dc);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; load_val = '0; stop = 1'b0; done_clr = 1'b0;
    prescale = '0; auto_reload = 1'b0;
    m_run = 0; m_cnt = 0; m_reload = 0; m_phase = 0; m_tc = 0; m_done = 0;
    @(negedge clk);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    check("reset_count", 32'(count), 32'd0);
    check("reset_busy",  32'(busy),  32'd0);

    // One-shot, prescale 0, load 5
    step(1'b0, 1'b1, 8'd5, 1'b0, 1'b0);
    idle(7, 1'b0);
    check("oneshot_done_sticky", 32'(done), 32'd1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Prescale 2, load 3: tc nine cycles after load
    prescale = 4'd2;
    step(1'b0, 1'b1, 8'd3, 1'b0, 1'b0);
    idle(11, 1'b0);

    // Auto-reload with done_clr held across expiries
    prescale = 4'd0; auto_reload = 1'b1;
    step(1'b0, 1'b1, 8'd4, 1'b0, 1'b0);
    idle(6, 1'b0);
    idle(6, 1'b1);
    check("autoreload_busy", 32'(busy), 32'd1);

    // Stop at count 2, then reload 7 with prescale 1
    auto_reload = 1'b0;
    step(1'b0, 1'b1, 8'd5, 1'b0, 1'b0);
    idle(3, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("stop_hold", 32'(count), 32'd2);
    idle(3, 1'b0);
    prescale = 4'd1;
    step(1'b0, 1'b1, 8'd7, 1'b0, 1'b0);
    idle(5, 1'b0);

    // Load 0, then load coinciding with a pending tick at count 1
    prescale = 4'd0;
    step(1'b0, 1'b1, 8'd0, 1'b0, 1'b1);
    idle(2, 1'b0);
    step(1'b0, 1'b1, 8'd2, 1'b0, 1'b0);
    idle(1, 1'b0);
    step(1'b0, 1'b1, 8'd9, 1'b0, 1'b0);
    check("load_over_tick_tc", 32'(tc), 32'd0);
    idle(3, 1'b0);

    // Reset mid-run, then a fresh load 2
    step(1'b0, 1'b1, 8'd4, 1'b0, 1'b0);
    idle(1, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'd2, 1'b0, 1'b0);
    idle(4, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic          r, l, st, dc;
      logic [W-1:0]  lv;
      if ($urandom_range(0, 49) == 0) prescale = PW'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) prescale = PW'($urandom);
      if ($urandom_range(0, 29) == 0) auto_reload = 1'($urandom);
      r  = ($urandom_range(0, 299) == 0);
      l  = ($urandom_range(0, 24) == 0);
      st = ($urandom_range(0, 59) == 0);
      dc = ($urandom_range(0, 14) == 0);
      lv = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 6)) : W'($urandom);
      step(r, l, lv, st, dc);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
